// File: rtl/hazard_ctrl_mc_if.sv
// hazard_ctrl_mc_if: hazard-unit signals between the pipeline stages (master) and hazard_ctrl_mc (slave).
interface hazard_ctrl_mc_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic                  RegWriteM, RegWriteW, PCSrcE, McOpE;
   logic [1:0]            ResultSrcE, ForwardAE, ForwardBE;
   logic                  StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
   logic [CNT_W-1:0]      StallCount;
   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McOpE,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, StallCount
   );
   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McOpE,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, StallCount
   );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: forwarding, load-use stall, branch-shadow flush and multi-cycle execute-op
// stall control for the 5-stage RV32I pipeline, plus a saturating stall-cycle counter.
module hazard_ctrl_mc #(
   parameter int REG_ADDR_W    = 5,
   parameter int MC_LATENCY    = 4,
   parameter int BRANCH_SHADOW = 1,
   parameter int CNT_W         = 16
) (
   input logic             clk,
   input logic             rst,
   hazard_ctrl_mc_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [7:0] MC_INIT = 8'(MC_LATENCY - 2);
   localparam logic [3:0] SH_INIT = 4'(BRANCH_SHADOW - 1);
   state_t           state_q, state_d;
   logic [7:0]       mc_cnt_q, mc_cnt_d;
   logic [3:0]       shadow_cnt_q, shadow_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             mc_start, mc_stall, lu, stall_f;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q      <= IDLE;
         mc_cnt_q     <= '0;
         shadow_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         mc_cnt_q     <= mc_cnt_d;
         shadow_cnt_q <= shadow_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   // A taken branch wins over a multi-cycle op seen in the same cycle.
   always_comb begin
      mc_start     = state_q == IDLE && bus.McOpE && !bus.PCSrcE;
      state_d      = mc_start ? BUSY : (state_q == BUSY && mc_cnt_q == '0) ? IDLE : state_q;
      mc_cnt_d     = mc_start ? MC_INIT : (mc_cnt_q != '0) ? mc_cnt_q - 8'd1 : mc_cnt_q;
      shadow_cnt_d = bus.PCSrcE ? SH_INIT : (shadow_cnt_q != '0) ? shadow_cnt_q - 4'd1 : shadow_cnt_q;
      stall_cnt_d  = stall_cnt_q + CNT_W'(stall_f && stall_cnt_q != '1);
   end
   // Load-use is masked while the op holds E so its D/E register is never flushed.
   always_comb begin
      mc_stall       = mc_start || (state_q == BUSY && mc_cnt_q != '0);
      lu             = bus.ResultSrcE == 2'b01 && bus.RdE != '0 &&
                       (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D) && !mc_stall;
      stall_f        = rst && !bus.PCSrcE && (mc_stall || lu);
      bus.ForwardAE  = !rst ? 2'b00 :
                       (bus.RegWriteM && bus.RdM != '0 && bus.RdM == bus.Rs1E) ? 2'b10 :
                       (bus.RegWriteW && bus.RdW != '0 && bus.RdW == bus.Rs1E) ? 2'b01 : 2'b00;
      bus.ForwardBE  = !rst ? 2'b00 :
                       (bus.RegWriteM && bus.RdM != '0 && bus.RdM == bus.Rs2E) ? 2'b10 :
                       (bus.RegWriteW && bus.RdW != '0 && bus.RdW == bus.Rs2E) ? 2'b01 : 2'b00;
      bus.StallF     = stall_f;
      bus.StallD     = stall_f;
      bus.StallE     = rst && mc_stall;
      bus.FlushM     = rst && mc_stall;
      bus.FlushD     = !rst || bus.PCSrcE || shadow_cnt_q != '0;
      bus.FlushE     = !rst || bus.PCSrcE || lu;
      bus.McBusy     = rst && state_q == BUSY;
      bus.StallCount = stall_cnt_q;
   end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed and random stimulus against a cycle-age / timestamp model of the
// hazard controller, compared on every falling clock edge.
module tb_hazard_ctrl_mc;
   localparam int RW = 5, L = 4, SH = 3, CW = 6;
   localparam int MAXC = (1 << CW) - 1;
   typedef struct packed {
      logic [1:0]    fa, fb;
      logic          sf, sd, se, fd, fe, fm, busy;
      logic [CW-1:0] sc;
   } exp_t;
   logic clk = 0, rst = 0;
   int total = 0, bad = 0;
   int held, cyc, last_br, cnt;
   always #5 clk = ~clk;
   hazard_ctrl_mc_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();
   hazard_ctrl_mc #(.REG_ADDR_W(RW), .MC_LATENCY(L), .BRANCH_SHADOW(SH), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask
   function automatic logic [1:0] fwd(input logic [RW-1:0] rs);
      if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
      if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
      return 2'b00;
   endfunction
   // held = cycles the current multi-cycle op has already spent in E
   function automatic logic mc_now();
      return (held == 0) ? (bus.McOpE && !bus.PCSrcE) : (held + 1 < L);
   endfunction
   function automatic logic lu_now();
      return bus.ResultSrcE == 2'b01 && bus.RdE != 0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
   endfunction
   function automatic logic stall_now();
      return !bus.PCSrcE && (mc_now() || lu_now());
   endfunction
   function automatic exp_t expect_now();
      exp_t e;
      e = '0;
      if (!rst) begin
         e.fd = 1;
         e.fe = 1;
         return e;
      end
      e.fa   = fwd(bus.Rs1E);
      e.fb   = fwd(bus.Rs2E);
      e.sf   = stall_now();
      e.sd   = stall_now();
      e.se   = mc_now();
      e.fm   = mc_now();
      e.fe   = bus.PCSrcE || (lu_now() && !mc_now());
      e.fd   = bus.PCSrcE || (cyc - last_br < SH);
      e.busy = held > 0;
      e.sc   = CW'(cnt);
      return e;
   endfunction
   always @(posedge clk or negedge rst)
      if (!rst) begin
         held    <= 0;
         cyc     <= 0;
         last_br <= -100;
         cnt     <= 0;
      end else begin
         if (stall_now() && cnt < MAXC) cnt <= cnt + 1;
         if (bus.PCSrcE) last_br <= cyc;
         if (held > 0 || (bus.McOpE && !bus.PCSrcE)) held <= (held + 1 < L) ? held + 1 : 0;
         cyc <= cyc + 1;
      end
   always @(negedge clk) begin
      chk("ForwardAE", bus.ForwardAE, expect_now().fa);
      chk("ForwardBE", bus.ForwardBE, expect_now().fb);
      chk("StallF", bus.StallF, expect_now().sf);
      chk("StallD", bus.StallD, expect_now().sd);
      chk("StallE", bus.StallE, expect_now().se);
      chk("FlushD", bus.FlushD, expect_now().fd);
      chk("FlushE", bus.FlushE, expect_now().fe);
      chk("FlushM", bus.FlushM, expect_now().fm);
      chk("McBusy", bus.McBusy, expect_now().busy);
      chk("StallCount", bus.StallCount, expect_now().sc);
   end
   task automatic next();
      @(posedge clk);
      #1;
   endtask
   task automatic clear();
      {bus.Rs1D, bus.Rs2D, bus.Rs1E, bus.Rs2E, bus.RdE, bus.RdM, bus.RdW} = '0;
      {bus.RegWriteM, bus.RegWriteW, bus.PCSrcE, bus.McOpE} = '0;
      bus.ResultSrcE = 2'b00;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end
   initial begin
      clear();
      #2;
      chk("rst_FlushD", bus.FlushD, 1);
      chk("rst_FlushE", bus.FlushE, 1);
      chk("rst_StallF", bus.StallF, 0);
      chk("rst_McBusy", bus.McBusy, 0);
      chk("rst_StallCount", bus.StallCount, 0);
      next(); next();
      rst = 1;
      bus.Rs1E = 5; bus.RdM = 5; bus.RdW = 5; bus.RegWriteM = 1; bus.RegWriteW = 1;
      #1 chk("fwd_M_prio", bus.ForwardAE, 2'b10);
      bus.RegWriteM = 0;
      #1 chk("fwd_W", bus.ForwardAE, 2'b01);
      bus.RegWriteM = 1; bus.RdM = 0; bus.RdW = 0;
      #1 chk("fwd_x0", bus.ForwardAE, 2'b00);
      bus.Rs2E = 9; bus.RdW = 9;
      #1 chk("fwdB_W", bus.ForwardBE, 2'b01);
      next();
      clear();
      bus.ResultSrcE = 2'b01; bus.RdE = 7; bus.Rs2D = 7;
      #1 chk("lu_StallF", bus.StallF, 1);
      chk("lu_FlushE", bus.FlushE, 1);
      chk("lu_cnt_before", bus.StallCount, 0);
      next();
      clear();
      #1 chk("lu_cnt_after", bus.StallCount, 1);
      bus.ResultSrcE = 2'b01;
      #1 chk("lu_rd0", bus.StallF, 0);
      next();
      clear();
      bus.McOpE = 1;
      for (int c = 1; c <= 4; c++) begin
         #1 chk("mc_StallF", bus.StallF, c < 4);
         chk("mc_FlushM", bus.FlushM, c < 4);
         chk("mc_McBusy", bus.McBusy, c >= 2);
         next();
      end
      bus.McOpE = 0;
      #1 chk("mc_idle", bus.McBusy, 0);
      chk("mc_cnt", bus.StallCount, 4);
      next();
      for (int c = 1; c <= 4; c++) begin
         bus.McOpE = 1; bus.RdE = 7; bus.Rs1D = 7;
         bus.ResultSrcE = (c < 4) ? 2'b01 : 2'b00;
         #1 chk("mclu_FlushE", bus.FlushE, 0);
         chk("mclu_StallE", bus.StallE, c < 4);
         next();
      end
      clear();
      #1 chk("mclu_cnt", bus.StallCount, 7);
      next();
      bus.PCSrcE = 1;
      for (int c = 1; c <= 4; c++) begin
         #1 chk("br_FlushD", bus.FlushD, c <= 3);
         next();
         bus.PCSrcE = 0;
      end
      for (int c = 1; c <= 5; c++) begin
         bus.PCSrcE = c <= 2;
         #1 chk("br2_FlushD", bus.FlushD, c <= 4);
         next();
      end
      bus.PCSrcE = 1; bus.ResultSrcE = 2'b01; bus.RdE = 7; bus.Rs2D = 7;
      #1 chk("br_lu_StallF", bus.StallF, 0);
      chk("br_lu_FlushE", bus.FlushE, 1);
      next();
      clear();
      bus.PCSrcE = 1; bus.McOpE = 1;
      #1 chk("br_mc_StallE", bus.StallE, 0);
      next();
      clear();
      #1 chk("br_mc_idle", bus.McBusy, 0);
      next(); next(); next();
      bus.McOpE = 1;
      next(); next();
      #1 chk("mid_busy", bus.McBusy, 1);
      rst = 0;
      #1 chk("mid_McBusy", bus.McBusy, 0);
      chk("mid_FlushD", bus.FlushD, 1);
      chk("mid_FlushE", bus.FlushE, 1);
      chk("mid_StallCount", bus.StallCount, 0);
      next();
      rst = 1; bus.McOpE = 0;
      #1 chk("post_StallF", bus.StallF, 0);
      chk("post_McBusy", bus.McBusy, 0);
      for (int i = 0; i < 2000; i++) begin
         bus.Rs1D = RW'($urandom_range(0, 3));
         bus.Rs2D = RW'($urandom_range(0, 3));
         bus.Rs1E = RW'($urandom_range(0, 3));
         bus.Rs2E = RW'($urandom_range(0, 3));
         bus.RdE  = RW'($urandom_range(0, 3));
         bus.RdM  = RW'($urandom_range(0, 3));
         bus.RdW  = RW'($urandom_range(0, 3));
         bus.RegWriteM  = 1'($urandom);
         bus.RegWriteW  = 1'($urandom);
         bus.ResultSrcE = 2'($urandom);
         bus.PCSrcE = $urandom_range(0, 9) == 0;
         bus.McOpE  = $urandom_range(0, 5) == 0;
         next();
      end
      clear();
      bus.McOpE = 1;
      for (int i = 0; i < 120; i++) next();
      #1 chk("sat_StallCount", bus.StallCount, MAXC);
      clear();
      next(); next();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
